// File: rtl/note_tone_player_pkg.sv
// music_pkg: shared types and default widths for the note player datapath.
//   player_state_t : IDLE -> START -> PLAY -> [GAP] -> IDLE
//   PERIOD_W       : half-period / downstream counter width
//   DUR_W          : note duration width, in clock cycles
//   GAP_CYCLES     : silent cycles after each note (only built with NOTE_GAP_EN)
package music_pkg;

    localparam int PERIOD_W   = 8;
    localparam int DUR_W      = 16;
    localparam int GAP_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } player_state_t;

endpackage

// File: rtl/note_tone_player_if.sv
// note_tone_player_if: valid/ready note handshake from the song sequencer.
//   note_valid  : source -> player, note fields valid
//   note_ready  : player -> source, note can be accepted
//   note_period : half-period in cycles, 0 = rest
//   note_dur    : duration in cycles, 0 = discard
// Modports: master (sequencer side), slave (player side).
interface note_tone_player_if #(
    parameter int PERIOD_W = music_pkg::PERIOD_W,
    parameter int DUR_W    = music_pkg::DUR_W
) ();
    logic                note_valid;
    logic                note_ready;
    logic [PERIOD_W-1:0] note_period;
    logic [DUR_W-1:0]    note_dur;

    modport master (output note_valid, note_period, note_dur, input note_ready);
    modport slave  (input note_valid, note_period, note_dur, output note_ready);
endinterface

// File: rtl/note_tone_player_dur_timer.sv
// note_dur_timer: loadable down-counter with a last-cycle flag.
// Used for both the note duration and the post-note gap.
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_val (wins over i_en)
//   i_val      : load value
//   i_en       : count down by one; holds at 1 so it never wraps
//   o_last     : count is 1, i.e. this is the final cycle of the interval
module note_dur_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_last
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_cnt <= '0;
        else if (i_load)                   r_cnt <= i_val;
        else if (i_en && (r_cnt > W'(1)))  r_cnt <= r_cnt - W'(1);
    end

    assign o_last = (r_cnt == W'(1));
endmodule

// File: rtl/note_tone_player.sv
// note_tone_player: accepts (half-period, duration) notes and plays them as a
// square wave, using an external 8-bit loadable down-counter for the pitch.
// Build option: NOTE_GAP_EN adds GAP_CYCLES silent busy cycles after each note.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   s_note     : note handshake (slave modport); ready only in IDLE
//   cnt_load   : load strobe to the downstream counter
//   cnt_in     : counter reload value (period-1), 0 when not loading
//   cnt_done   : counter-at-zero from the downstream counter
//   audio      : registered square-wave output
//   busy       : player is not in IDLE
module note_tone_player #(
    parameter int PERIOD_W   = music_pkg::PERIOD_W,
    parameter int DUR_W      = music_pkg::DUR_W
`ifdef NOTE_GAP_EN
   ,parameter int GAP_CYCLES = music_pkg::GAP_CYCLES
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    note_tone_player_if.slave   s_note,
    output logic                cnt_load,
    output logic [PERIOD_W-1:0] cnt_in,
    input  logic                cnt_done,
    output logic                audio,
    output logic                busy
);
    import music_pkg::*;

    player_state_t       r_state;
    logic [PERIOD_W-1:0] r_period;
    logic [DUR_W-1:0]    r_dur;
    logic                r_audio;

    logic                w_tone;
    logic                w_last;
    logic                w_tmr_load;
    logic [DUR_W-1:0]    w_tmr_val;
    logic                w_tmr_en;
    logic [PERIOD_W-1:0] w_reload;

    assign w_tone   = (r_period != '0);
    assign w_reload = r_period - PERIOD_W'(1);

    // One timer serves the note duration and, when built, the gap. The load
    // on the last PLAY cycle overrides that cycle's decrement.
`ifdef NOTE_GAP_EN
    assign w_tmr_load = (r_state == START) || ((r_state == PLAY) && w_last);
    assign w_tmr_val  = (r_state == START) ? r_dur : DUR_W'(GAP_CYCLES);
    assign w_tmr_en   = (r_state == PLAY) || (r_state == GAP);
`else
    assign w_tmr_load = (r_state == START);
    assign w_tmr_val  = r_dur;
    assign w_tmr_en   = (r_state == PLAY);
`endif

    note_dur_timer #(.W(DUR_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .i_en   (w_tmr_en),
        .o_last (w_last)
    );

    // Reload on the START cycle and on each counter expiry in PLAY, except on
    // the final note cycle where the note ends instead. Rests never load, so
    // the period-1 underflow value is never driven.
    always_comb begin
        cnt_load = 1'b0;
        if (w_tone) begin
            if (r_state == START)
                cnt_load = 1'b1;
            else if ((r_state == PLAY) && cnt_done && !w_last)
                cnt_load = 1'b1;
        end
    end

    assign cnt_in = cnt_load ? w_reload : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_period <= '0;
            r_dur    <= '0;
            r_audio  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_note.note_valid) begin
                        r_period <= s_note.note_period;
                        r_dur    <= s_note.note_dur;
                        // Zero-duration notes are consumed and dropped.
                        if (s_note.note_dur != '0)
                            r_state <= START;
                    end
                end
                START: r_state <= PLAY;
                PLAY: begin
                    if (w_last) begin
                        r_audio <= 1'b0;
`ifdef NOTE_GAP_EN
                        r_state <= GAP;
`else
                        r_state <= IDLE;
`endif
                    end else if (w_tone && cnt_done) begin
                        r_audio <= ~r_audio;
                    end
                end
`ifdef NOTE_GAP_EN
                GAP: begin
                    if (w_last)
                        r_state <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_note.note_ready = (r_state == IDLE);
    assign busy              = (r_state != IDLE);
    assign audio             = r_audio;
endmodule

// File: tb/tb_note_tone_player.sv
// Testbench for note_tone_player: directed literal checks plus randomized notes
// checked every cycle against a closed-form model of the expected waveform.
module tb_note_tone_player;
    localparam int PW = music_pkg::PERIOD_W;
    localparam int DW = music_pkg::DUR_W;
`ifdef NOTE_GAP_EN
    localparam int G = music_pkg::GAP_CYCLES;
`else
    localparam int G = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cnt_load;
    logic [PW-1:0] cnt_in;
    logic          cnt_done;
    logic          audio;
    logic          busy;
    logic [PW-1:0] c_cnt;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  chk_en = 0;

    // model of the current note: START at m_T, PLAY for m_d cycles, then G gap
    bit  m_has = 0;
    int  m_T, m_p, m_d;

    note_tone_player_if nif ();

    note_tone_player dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_note   (nif),
        .cnt_load (cnt_load),
        .cnt_in   (cnt_in),
        .cnt_done (cnt_done),
        .audio    (audio),
        .busy     (busy)
    );

    // downstream loadable down-counter, holds at zero
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        c_cnt <= '0;
        else if (cnt_load) c_cnt <= cnt_in;
        else if (c_cnt != 0) c_cnt <= c_cnt - 1'b1;
    end
    assign cnt_done = (c_cnt == '0);

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a note and hold it until accepted; returns cycles spent waiting.
    // Returns at +1 of the cycle after acceptance (START for a non-zero dur).
    task automatic send(input int p, input int d, output int waited);
        int n;
        n = 0;
        nif.note_valid  = 1'b1;
        nif.note_period = PW'(p);
        nif.note_dur    = DW'(d);
        #1;
        while (!nif.note_ready && n < 300) begin
            tick();
            #1;
            n++;
        end
        chk("ready_wait", {31'd0, nif.note_ready}, 1);
        tick();
        nif.note_valid = 1'b0;
        waited = n;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 0);
    endtask

    // per-cycle compare against the closed-form note waveform
    always @(negedge clk) begin : cmp
        int  j, ei, au;
        bit  bz, ld;
        if (!rst_n) begin
            m_has = 0;
        end else if (chk_en) begin
            if (m_has && cyc > m_T + m_d + G) m_has = 0;
            bz = m_has;
            j  = cyc - m_T;
            ld = 0; au = 0; ei = 0;
            if (bz && m_p != 0) begin
                ld = (j == 0) || (j >= 1 && j <= m_d - 1 && (j % m_p) == 0);
                au = (j >= 1 && j <= m_d) ? (((j - 1) / m_p) % 2) : 0;
                ei = ld ? m_p - 1 : 0;
            end
            chk("m_busy",  {31'd0, busy}, {31'd0, bz});
            chk("m_ready", {31'd0, nif.note_ready}, {31'd0, !bz});
            chk("m_load",  {31'd0, cnt_load}, {31'd0, ld});
            chk("m_cnt_in", {24'd0, cnt_in}, ei);
            chk("m_audio", {31'd0, audio}, au);
            if (!bz && nif.note_valid && nif.note_dur != 0) begin
                m_has = 1;
                m_T   = cyc + 1;
                m_p   = int'(nif.note_period);
                m_d   = int'(nif.note_dur);
            end
        end
    end

    initial begin
        int w, nb, nl, p, d;
        bit [13:1] ea;
        ea = 13'b0111000111000;
        nif.note_valid = 0; nif.note_period = '0; nif.note_dur = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_audio", {31'd0, audio}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, nif.note_ready}, 1);
        chk("rst_load", {31'd0, cnt_load}, 0);
        chk("rst_cnt_in", {24'd0, cnt_in}, 0);
        rst_n  = 1;
        chk_en = 1;
        tick();

        // tone: period 3, dur 12
        send(3, 12, w);
        chk("tone_wait", w, 0);
        chk("tone_T_load", {31'd0, cnt_load}, 1);
        chk("tone_T_in", {24'd0, cnt_in}, 2);
        for (int j = 1; j <= 13; j++) begin
            tick();
            chk("tone_audio", {31'd0, audio}, {31'd0, ea[j]});
            if (j == 3 || j == 6 || j == 9) chk("tone_reload", {31'd0, cnt_load}, 1);
            if (j == 12) chk("tone_last_noload", {31'd0, cnt_load}, 0);
        end
        chk("tone_end_ready", {31'd0, nif.note_ready}, (G == 0) ? 1 : 0);
        wait_idle();

        // rest: period 0, dur 5
        send(0, 5, w);
        nb = 0; nl = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) nb++;
            if (cnt_load) nl++;
            tick();
        end
        chk("rest_busy_cycles", nb, 6 + G);
        chk("rest_loads", nl, 0);
        chk("rest_ready", {31'd0, nif.note_ready}, 1);

        // zero duration
        send(3, 0, w);
        chk("zero_wait", w, 0);
        chk("zero_busy", {31'd0, busy}, 0);
        chk("zero_ready", {31'd0, nif.note_ready}, 1);
        chk("zero_load", {31'd0, cnt_load}, 0);
        tick();

        // backpressure: second note waits for IDLE
        send(2, 8, w);
        send(5, 3, w);
        chk("bp_wait", w, 9 + G);
        chk("bp_load", {31'd0, cnt_load}, 1);
        chk("bp_cnt_in", {24'd0, cnt_in}, 4);
        wait_idle();

        // gap / plain note period 2 dur 6
        send(2, 6, w);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) nb++;
            tick();
        end
        chk("p2_busy_cycles", nb, 7 + G);

        // async reset mid-PLAY
        send(5, 30, w);
        repeat (7) tick();
        chk("pre_rst_audio", {31'd0, audio}, 1);
        #1 rst_n = 0;
        #1;
        chk("arst_audio", {31'd0, audio}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ready", {31'd0, nif.note_ready}, 1);
        chk("arst_load", {31'd0, cnt_load}, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        send(4, 9, w);
        chk("post_rst_load", {31'd0, cnt_load}, 1);
        chk("post_rst_in", {24'd0, cnt_in}, 3);
        wait_idle();

        // randomized notes, sometimes offered while busy
        for (int n = 0; n < 40; n++) begin
            p = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
            d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
            send(p, d, w);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
